// File: rtl/alu_sched_if.sv
// Bundle of request, ALU and response signals for the alu_sched scheduler.
// Optional resp_zero member exists only when ALU_SCHED_ZERO_FLAG_EN is defined.
interface alu_sched_if #(
    parameter int CNT_W = 16
) ();
    // Handshake rule for req0, req1 and resp: a transfer happens on a rising
    // clock edge where valid and ready are both high; the sender holds valid
    // and its payload stable until that edge.
    logic             req0_valid;
    logic             req0_ready;
    logic [7:0]       req0_a;
    logic [7:0]       req0_b;
    logic [2:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [7:0]       req1_a;
    logic [7:0]       req1_b;
    logic [2:0]       req1_op;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [2:0]       alu_opcode;
    logic [7:0]       alu_out;
    logic             resp_valid;
    logic             resp_ready;
    logic [7:0]       resp_data;
    logic             resp_id;
    logic             busy;
    logic [CNT_W-1:0] ops_done;
`ifdef ALU_SCHED_ZERO_FLAG_EN
    logic             resp_zero;
`endif

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_out, resp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_opcode,
        output resp_valid, resp_data, resp_id, busy, ops_done
`ifdef ALU_SCHED_ZERO_FLAG_EN
        , output resp_zero
`endif
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_out, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_opcode,
        input  resp_valid, resp_data, resp_id, busy, ops_done
`ifdef ALU_SCHED_ZERO_FLAG_EN
        , input resp_zero
`endif
    );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one external 8-bit ALU between two requesters.
// Define ALU_SCHED_ZERO_FLAG_EN to add the registered resp_zero output.
module alu_sched #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    alu_sched_if.slave  bus,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             rr_last_q;
    logic             id_q;
    logic [7:0]       alu_a_q;
    logic [7:0]       alu_b_q;
    logic [2:0]       alu_op_q;
    logic             resp_valid_q;
    logic [7:0]       resp_data_q;
    logic             resp_id_q;
    logic [CNT_W-1:0] ops_q;

    // A requester that is alone wins; on a tie the one that did not win last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && (!bus.req1_valid || rr_last_q))
                grant0 = 1'b1;
            else if (bus.req1_valid)
                grant1 = 1'b1;
        end
    end

    assign accept = grant0 | grant1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            alu_op_q     <= 3'b111;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'h00;
            resp_id_q    <= 1'b0;
            ops_q        <= '0;
            rr_last_q    <= 1'b1;
            id_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a_q   <= grant1 ? bus.req1_a  : bus.req0_a;
                alu_b_q   <= grant1 ? bus.req1_b  : bus.req0_b;
                alu_op_q  <= grant1 ? bus.req1_op : bus.req0_op;
                id_q      <= grant1;
                rr_last_q <= grant1;
            end
            if (state_q == EXEC) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= bus.alu_out;
                resp_id_q    <= id_q;
            end
            if (state_q == RESP && bus.resp_ready) begin
                resp_valid_q <= 1'b0;
                ops_q        <= ops_q + CNT_W'(1);
            end
        end
    end

`ifdef ALU_SCHED_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk) begin
        if (rst)
            zero_q <= 1'b0;
        else if (state_q == EXEC)
            zero_q <= (bus.alu_out == 8'h00);
    end

    assign bus.resp_zero = zero_q;
`endif

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.ops_done   = ops_q;
    assign dbg_state      = state_q;
endmodule
